matrix_scroller: RTL and testbench
==================================

# matrix_scroller

Upstream feeder for the 8×8 bicolour LED matrix scanner. Holds a column-addressed image wider than the panel, loaded one column per handshake. It scrolls an 8-column window across that image with wrap-around at a programmable rate. It drives the scanner's 128-bit frame bus directly from a register, so the scanner always sees a stable, fully formed frame.

## Interface
Parameters:
- COLS, 32, image width in columns (8..256)
- STEP_DIV, 250, clk cycles per scroll step (≥1); 250 at 1 kHz gives 4 steps/s

Ports:
- clk  in  1  system clock (nominal 1 kHz, same as scanner)
- rst  in  1  reset, synchronous, active-high
- load  in  1  pulse: clear image, enter loading
- wr_valid  in  1  column beat valid
- wr_ready  out  1  column beat accepted when wr_valid & wr_ready
- wr_col  in  16  column data; bits [2r+1:2r] = {G,R} for row r (r=0 top)
- wr_last  in  1  last column of image (qualifies beat)
- pause  in  1  level: freeze scrolling
- dir  in  1  0 = scroll left (offset +1), 1 = scroll right (offset −1)
- data  out  128  frame to scanner: row r in [(7−r)*16 +: 16]; cell i of that row: bit 2i = R, bit 2i+1 = G; 1 = lit
- step  out  1  one-cycle pulse when offset changes
- busy  out  1  high in LOAD

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - data held at 0.
  - wr_ready = 0.
  - load → LOAD.
- LOAD entry (cycle after load):
  - all COLS columns cleared to 0; wptr = 0; ofs = 0; divider = 0; wr_ready = 1; busy = 1.
- LOAD beats:
  - each accepted beat writes buf[wptr], then wptr++.
  - Accepted beat with wr_last, or with wptr == COLS−1 → RUN next cycle.
  - Unwritten columns stay 0.
  - load asserted in LOAD is ignored.
- RUN:
  - wr_ready = 0.
  - divider counts 0..STEP_DIV−1 while pause = 0.
  - On terminal count: ofs ← (ofs ± 1) mod COLS, per dir; step pulses; divider → 0.
  - pause = 1 holds both divider and ofs.
  - load → LOAD (restart).
- Window: column i of frame (i = 0..7) = buf[(ofs + i) mod COLS].
  - Row r of cell i = buf[..][2r+1:2r].
  - Wrap-around is seamless.
- Arithmetic:
  - ofs and wptr are clog2(COLS) bits wide.
  - Modulo is explicit compare-and-wrap, so it is correct for non-power-of-two COLS.
  - Right scroll from 0 gives COLS−1.
- Priority: rst > load > step.
- dir change takes effect at the next step; there is no jump.

## Timing
- Reset values: state = IDLE, data = 0, wr_ready = 0, busy = 0, step = 0, ofs = 0, wptr = 0, divider = 0, buffer = 0.
- rst mid-LOAD or mid-RUN discards the image. All outputs return to reset values on the next edge.
- data is registered. It reflects buffer/ofs one cycle after they change:
  - first frame appears 1 cycle after entering RUN;
  - after a step, the new frame appears 1 cycle after step.
- data stays 0 throughout LOAD.
- The frame never changes mid-cycle, so the scanner may sample on any edge.
- wr_ready is a pure function of state and never depends on wr_valid.
  - Beats while wr_ready = 0 are dropped.
- First step occurs STEP_DIV cycles after entering RUN (with pause low throughout).

## Structure
- Package matrix_pkg holds:
  - state enum;
  - ROWS = 8, WIN = 8, CELL_W = 2, R_BIT = 0, G_BIT = 1;
  - a function mapping (row, col) to the data bit index, shared with the scanner.
- One sub-module, matrix_colbuf: COLS×16 register array with synchronous clear, write port, and 8-wide wrapped read window at ofs.
- FSM, divider and output register stay in matrix_scroller.

## Test plan
- Reset:
  - Stimulus: hold rst 3 cycles with garbage on all inputs.
  - Required: data = 0, wr_ready = 0, busy = 0, step = 0; state IDLE.
- Load and display:
  - Stimulus: COLS = 32, load, then 32 beats with wr_col = column index replicated.
  - Required: wr_ready high for exactly those beats; RUN entered after beat 31.
  - Required, 1 cycle later: frame column i = buf[i]; e.g. column 0 all-off, column 1 R on in all rows.
- Early wr_last:
  - Stimulus: 3 beats of 16'hFFFF, third with wr_last.
  - Required: RUN next cycle; columns 3..31 read 0.
  - Required, after 30 left steps: window columns 2..4 = all lit yellow (wrap-around).
- Step rate and direction:
  - Stimulus: STEP_DIV = 4, pause low.
  - Required: step every 4th cycle; ofs 0→1→2.
  - Stimulus: set dir = 1 starting from ofs 0.
  - Required: ofs 0→31.
- Pause:
  - Stimulus: pause high for 10 cycles mid-count (divider = 2).
  - Required: no step, data unchanged; after release, step 2 cycles later.
- Reload and mid-operation reset:
  - Stimulus: load during RUN.
  - Required: data = 0 and busy = 1 next cycle; ofs = 0.
  - Stimulus: rst during beat 5 of LOAD.
  - Required: IDLE next cycle; a subsequent load shows no stale columns.

Source files
------------

// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared types, geometry constants and frame bit mapping for
//               the 8x8 bicolour LED matrix scroller and scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int ROWS     = 8;
    localparam int WIN      = 8;
    localparam int CELL_W   = 2;
    localparam int R_BIT    = 0;
    localparam int G_BIT    = 1;
    localparam int COL_W    = ROWS * CELL_W;
    localparam int FRAME_W  = ROWS * WIN * CELL_W;
    localparam int FRAME_AW = $clog2(FRAME_W);

    // Row 0 is the top row and lives in the most significant 16 bits.
    function automatic logic [FRAME_AW-1:0] cell_bit(input int row, input int col,
                                                     input int color);
        return FRAME_AW'((ROWS - 1 - row) * WIN * CELL_W + col * CELL_W + color);
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_colbuf.sv
`default_nettype none
// ============================================================================
// Module      : matrix_colbuf
// Description : COLS x 16 column image store with synchronous clear, one
//               write port and an 8-wide wrapped read window at ofs_i.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_colbuf
    import matrix_pkg::*;
#(
    parameter int COLS = 32,
    parameter int AW   = $clog2(COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [COL_W-1:0]       wr_data_i,
    input  logic [AW-1:0]          ofs_i,
    output logic [WIN*COL_W-1:0]   window_o
);

    logic [COL_W-1:0] mem_q [COLS];

    // Column store: reset and clear wipe the whole image, otherwise one write per cycle.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            for (int c = 0; c < COLS; c++) begin
                mem_q[c] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Window column i reads (ofs + i) mod COLS; compare-and-wrap keeps
    // non-power-of-two widths correct since ofs + i < 2*COLS.
    for (genvar gi = 0; gi < WIN; gi++) begin : g_win
        logic [AW:0]   w_sum;
        logic [AW-1:0] w_idx;
        assign w_sum = {1'b0, ofs_i} + (AW+1)'(gi);
        assign w_idx = (w_sum >= (AW+1)'(COLS)) ? AW'(w_sum - (AW+1)'(COLS))
                                                : w_sum[AW-1:0];
        assign window_o[gi*COL_W +: COL_W] = mem_q[w_idx];
    end

endmodule
`default_nettype wire

// File: rtl/matrix_scroller.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scroller
// Description : Loads a column image over a valid/ready port and scrolls an
//               8-column wrapped window across it, presenting a registered
//               128-bit frame to the matrix scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_scroller
    import matrix_pkg::*;
#(
    parameter int COLS     = 32,
    parameter int STEP_DIV = 250
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [COL_W-1:0]     wr_col_i,
    input  logic                 wr_last_i,
    input  logic                 pause_i,
    input  logic                 dir_i,
    output logic [FRAME_W-1:0]   data_o,
    output logic                 step_o,
    output logic                 busy_o
);

    localparam int              AW       = $clog2(COLS);
    localparam int              DW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [AW-1:0]   LAST_COL = AW'(COLS - 1);
    localparam logic [DW-1:0]   DIV_TC   = DW'(STEP_DIV - 1);

    state_t               state_q, state_d;
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW-1:0]        ofs_q, ofs_d;
    logic [DW-1:0]        div_q, div_d;
    logic                 step_q, step_d;
    logic [FRAME_W-1:0]   data_q, data_d;

    logic                 w_wr_ready;
    logic                 w_busy;
    logic                 w_accept;
    logic                 w_last_beat;
    logic                 w_restart;
    logic                 w_tick;
    logic [WIN*COL_W-1:0] w_window;
    logic [FRAME_W-1:0]   w_frame;

    assign w_accept    = wr_valid_i && w_wr_ready;
    assign w_last_beat = w_accept && (wr_last_i || (wptr_q == LAST_COL));
    // load is honoured from IDLE and RUN only; a reload wins over a pending step.
    assign w_restart   = load_i && (state_q != ST_LOAD);
    assign w_tick      = (state_q == ST_RUN) && !load_i && !pause_i && (div_q == DIV_TC);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load_i)      state_d = ST_LOAD;
            ST_LOAD: if (w_last_beat) state_d = ST_RUN;
            ST_RUN:  if (load_i)      state_d = ST_LOAD;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs; ready never looks at valid.
    always_comb begin
        w_wr_ready = (state_q == ST_LOAD);
        w_busy     = (state_q == ST_LOAD);
    end

    // Write pointer, scroll offset and step divider next-state.
    always_comb begin
        wptr_d = wptr_q;
        ofs_d  = ofs_q;
        div_d  = div_q;
        step_d = w_tick;
        if (w_restart) begin
            wptr_d = '0;
            ofs_d  = '0;
            div_d  = '0;
        end else begin
            if (w_accept) begin
                wptr_d = (wptr_q == LAST_COL) ? '0 : wptr_q + 1'b1;
            end
            if ((state_q == ST_RUN) && !pause_i) begin
                if (w_tick) begin
                    div_d = '0;
                    if (dir_i) begin
                        ofs_d = (ofs_q == '0) ? LAST_COL : ofs_q - 1'b1;
                    end else begin
                        ofs_d = (ofs_q == LAST_COL) ? '0 : ofs_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        end
    end

    matrix_colbuf #(
        .COLS (COLS),
        .AW   (AW)
    ) u_colbuf (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (w_restart),
        .wr_en_i   (w_accept),
        .wr_addr_i (wptr_q),
        .wr_data_i (wr_col_i),
        .ofs_i     (ofs_q),
        .window_o  (w_window)
    );

    // Reorder window columns into the scanner's row-major frame layout.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < WIN; gc++) begin : g_cell
            assign w_frame[cell_bit(gr, gc, R_BIT)] = w_window[gc*COL_W + gr*CELL_W + R_BIT];
            assign w_frame[cell_bit(gr, gc, G_BIT)] = w_window[gc*COL_W + gr*CELL_W + G_BIT];
        end
    end

    // Frame is blank outside RUN and blanks immediately on a reload.
    always_comb begin
        data_d = ((state_q == ST_RUN) && !load_i) ? w_frame : '0;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            ofs_q  <= '0;
            div_q  <= '0;
            step_q <= 1'b0;
            data_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            ofs_q  <= ofs_d;
            div_q  <= div_d;
            step_q <= step_d;
            data_q <= data_d;
        end
    end

    assign wr_ready_o = w_wr_ready;
    assign busy_o     = w_busy;
    assign step_o     = step_q;
    assign data_o     = data_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_scroller
// Description : Directed self-checking bench for matrix_scroller
//               (COLS = 32, STEP_DIV = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_scroller;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_i;
    logic         wr_valid_i;
    logic         wr_ready_o;
    logic [15:0]  wr_col_i;
    logic         wr_last_i;
    logic         pause_i;
    logic         dir_i;
    logic [127:0] data_o;
    logic         step_o;
    logic         busy_o;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [15:0]  img [32];
    int           ready_cnt;

    matrix_scroller #(
        .COLS     (32),
        .STEP_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_col_i   (wr_col_i),
        .wr_last_i  (wr_last_i),
        .pause_i    (pause_i),
        .dir_i      (dir_i),
        .data_o     (data_o),
        .step_o     (step_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat(input int mode, input int k);
        logic [4:0] kk;
        kk = 5'(k);
        case (mode)
            0:       return {8{kk[1:0]}};
            1:       return 16'hFFFF;
            default: return {3'b000, kk, 3'b101, kk};
        endcase
    endfunction

    // Expected frame for a given offset from the bench's own image copy.
    function automatic logic [127:0] frame(input int ofs);
        logic [127:0] f;
        logic [15:0]  c;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            c = img[(ofs + i) % 32];
            for (int r = 0; r < 8; r++) begin
                f[(7 - r) * 16 + 2 * i]     = c[2 * r];
                f[(7 - r) * 16 + 2 * i + 1] = c[2 * r + 1];
            end
        end
        return f;
    endfunction

    // Pulse load and stream n beats; the last carries wr_last. Returns just
    // after the edge that accepted the final beat.
    task automatic load_image(input int n, input int mode);
        for (int i = 0; i < 32; i++) img[i] = '0;
        ready_cnt = 0;
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            img[k]     = pat(mode, k);
            wr_col_i   = pat(mode, k);
            wr_valid_i = 1'b1;
            wr_last_i  = (k == n - 1);
            if (wr_ready_o) ready_cnt++;
            tick();
        end
        wr_valid_i = 1'b0;
        wr_last_i  = 1'b0;
        wr_col_i   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_i = 1'b1; wr_valid_i = 1'b1; wr_col_i = 16'hDEAD;
        wr_last_i = 1'b1; pause_i = 1'b1; dir_i = 1'b1;
        repeat (3) tick();
        n_checks++; if (data_o !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_o); end
        n_checks++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (step_o !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b want 0", step_o); end
        rst = 1'b0; load_i = 1'b0; wr_valid_i = 1'b0; wr_col_i = '0;
        wr_last_i = 1'b0; pause_i = 1'b0; dir_i = 1'b0;
        tick();
        n_checks++; if (busy_o !== 1'b0 || wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL idle_hold: busy=%b ready=%b want 0 0", busy_o, wr_ready_o); end
    endtask

    task automatic test_load_display();
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        n_checks++; if (busy_o !== 1'b1 || wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL load_entry: busy=%b ready=%b want 1 1", busy_o, wr_ready_o); end
        n_checks++; if (data_o !== 128'h0) begin n_fail++; $display("FAIL load_data_zero: got %h want 0", data_o); end
        load_image(32, 0);
        n_checks++; if (ready_cnt !== 32) begin n_fail++; $display("FAIL ready_beats: got %0d want 32", ready_cnt); end
        n_checks++; if (wr_ready_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL run_entry: ready=%b busy=%b want 0 0", wr_ready_o, busy_o); end
        n_checks++; if (data_o !== 128'h0) begin n_fail++; $display("FAIL run_entry_data: got %h want 0", data_o); end
        tick();
        n_checks++; if (data_o !== {8{16'hE4E4}}) begin n_fail++; $display("FAIL first_frame: got %h want %h", data_o, {8{16'hE4E4}}); end
    endtask

    task automatic test_step_dir();
        logic [127:0] exp_d;
        int           ofs_m;
        dir_i = 1'b0;
        load_image(32, 2);
        ofs_m = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_d = frame(ofs_m);
            if (k % 4 == 0) ofs_m = ofs_m + 1;
            n_checks++; if (step_o !== (k % 4 == 0)) begin n_fail++; $display("FAIL left_step c%0d: got %b want %b", k, step_o, (k % 4 == 0)); end
            n_checks++; if (data_o !== exp_d) begin n_fail++; $display("FAIL left_frame c%0d: got %h want %h", k, data_o, exp_d); end
        end
        n_checks++; if (ofs_m !== 2) begin n_fail++; $display("FAIL left_ofs_model: got %0d want 2", ofs_m); end
        dir_i = 1'b1;
        load_image(32, 2);
        repeat (5) tick();
        n_checks++; if (data_o !== frame(31)) begin n_fail++; $display("FAIL right_wrap: got %h want %h", data_o, frame(31)); end
        repeat (4) tick();
        n_checks++; if (data_o !== frame(30)) begin n_fail++; $display("FAIL right_second: got %h want %h", data_o, frame(30)); end
        dir_i = 1'b0;
    endtask

    task automatic test_pause();
        load_image(32, 2);
        tick();
        tick();
        pause_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++; if (step_o !== 1'b0) begin n_fail++; $display("FAIL pause_step c%0d: got %b want 0", k, step_o); end
            n_checks++; if (data_o !== frame(0)) begin n_fail++; $display("FAIL pause_data c%0d: got %h want %h", k, data_o, frame(0)); end
        end
        pause_i = 1'b0;
        tick();
        n_checks++; if (step_o !== 1'b0) begin n_fail++; $display("FAIL release_step1: got %b want 0", step_o); end
        tick();
        n_checks++; if (step_o !== 1'b1) begin n_fail++; $display("FAIL release_step2: got %b want 1", step_o); end
        tick();
        n_checks++; if (data_o !== frame(1)) begin n_fail++; $display("FAIL release_frame: got %h want %h", data_o, frame(1)); end
    endtask

    task automatic test_early_last();
        load_image(3, 1);
        n_checks++; if (ready_cnt !== 3) begin n_fail++; $display("FAIL early_beats: got %0d want 3", ready_cnt); end
        n_checks++; if (busy_o !== 1'b0 || wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL early_run: busy=%b ready=%b want 0 0", busy_o, wr_ready_o); end
        tick();
        n_checks++; if (data_o !== {8{16'h003F}}) begin n_fail++; $display("FAIL early_frame: got %h want %h", data_o, {8{16'h003F}}); end
        repeat (120) tick();
        n_checks++; if (data_o !== {8{16'h03F0}}) begin n_fail++; $display("FAIL wrap_frame: got %h want %h", data_o, {8{16'h03F0}}); end
    endtask

    task automatic test_reload_reset();
        load_image(32, 2);
        repeat (5) tick();
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        n_checks++; if (data_o !== 128'h0) begin n_fail++; $display("FAIL reload_data: got %h want 0", data_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reload_busy: got %b want 1", busy_o); end
        load_image(32, 0);
        tick();
        n_checks++; if (data_o !== {8{16'hE4E4}}) begin n_fail++; $display("FAIL reload_ofs0: got %h want %h", data_o, {8{16'hE4E4}}); end
        // Reset in the middle of a fresh load.
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr_col_i = pat(2, k); wr_valid_i = 1'b1;
            tick();
        end
        wr_col_i = pat(2, 5); rst = 1'b1;
        tick();
        rst = 1'b0; wr_valid_i = 1'b0; wr_col_i = '0;
        n_checks++; if (busy_o !== 1'b0 || wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle: busy=%b ready=%b want 0 0", busy_o, wr_ready_o); end
        n_checks++; if (data_o !== 128'h0 || step_o !== 1'b0) begin n_fail++; $display("FAIL rst_outputs: data=%h step=%b want 0 0", data_o, step_o); end
        load_image(2, 1);
        tick();
        n_checks++; if (data_o !== {8{16'h000F}}) begin n_fail++; $display("FAIL no_stale: got %h want %h", data_o, {8{16'h000F}}); end
    endtask

    initial begin
        test_reset();
        test_load_display();
        test_step_dir();
        test_pause();
        test_early_last();
        test_reload_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
